id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising-edge active.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have: id_valid_i  in  1  decode stage holds a valid instruction.
REQ-004 SHALL have: id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i  in  32 each  decoded PC, operands, immediate.
REQ-005 SHALL have: id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  5 each  register indices.
REQ-006 SHALL have: id_opcode_i  in  7, id_func3_i  in  3  raw instruction fields.
REQ-007 SHALL have: cu_ALUctrl_i  in  5, cu_reg_we_i  in  1  control-unit decode results.
REQ-008 SHALL have: ex_ready_i  in  1  execute stage accepts current contents this cycle.
REQ-009 SHALL have: flush_i  in  1  redirect (taken branch/jump) from execute.
REQ-010 SHALL have: id_ex_ready_o  out  1  block accepts decode instruction this cycle.
REQ-011 SHALL have: load_use_stall_o  out  1  load-use hazard detected.
REQ-012 SHALL have: ex_valid_o  out  1, plus registered copies ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o (32), ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o (5), ex_opcode_o (7), ex_func3_o (3), ex_ALUctrl_o (5), ex_reg_we_o (1).

Function
REQ-013 SHALL define hold = ex_valid_o & ~ex_ready_i; free = ~hold.
REQ-014 SHALL compute load_use_stall_o = ~flush_i & id_valid_i & ex_valid_o & (ex_opcode_o == `Itype_L) & (ex_rd_addr_o != 0) & (ex_rd_addr_o == id_rs1_addr_i | ex_rd_addr_o == id_rs2_addr_i), combinationally.
REQ-015 SHALL compute id_ex_ready_o = flush_i | (free & ~load_use_stall_o), combinationally.
REQ-016 Priority per rising edge SHALL be: flush > hold > load-use bubble > accept > drain.
REQ-017 Flush: flush_i=1 SHALL load a bubble next cycle regardless of hold, stall or id_valid_i; incoming instruction is consumed and discarded.
REQ-018 Bubble SHALL mean ex_valid_o=0, ex_reg_we_o=0, ex_ALUctrl_o=`NO_OP, ex_opcode_o=0, ex_rd_addr_o=0; data fields don't-care but SHALL be zeroed.
REQ-019 Hold: hold=1 and flush_i=0 SHALL keep every ex_* output unchanged.
REQ-020 Load-use: free, load_use_stall_o=1 SHALL load a bubble; decode instruction stays pending upstream (ready=0), accepted the following cycle once hazard clears.
REQ-021 Accept: free, no stall, id_valid_i=1 SHALL capture all id_/cu_ inputs into ex_* and set ex_valid_o=1; latency one cycle.
REQ-022 Drain: free, id_valid_i=0 SHALL load a bubble.
REQ-023 Back-to-back accepts SHALL sustain one instruction per cycle with ex_ready_i held high.
REQ-024 Hazard check SHALL ignore rd=x0 and SHALL compare both sources even for instructions not reading rs2 (conservative).
REQ-025 ex_reg_we_o SHALL never be 1 while ex_valid_o=0.

Reset
REQ-026 rst_n=0 SHALL immediately, asynchronously force bubble state (REQ-018) on all ex_* outputs, independent of clk.
REQ-027 Reset asserted mid-hold or mid-stall SHALL discard the held instruction; first edge after release behaves per REQ-016 with ex_valid_o=0.
REQ-028 Combinational outputs after reset: id_ex_ready_o=1 (free), load_use_stall_o=0.

Verification
REQ-029 Accept: id_valid_i=1, pc=0x100, ALUctrl=`ADD, reg_we=1, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_pc_o=0x100, ex_ALUctrl_o=`ADD.
REQ-030 Hold: ex_valid_o=1 pc=0x100, ex_ready_i=0 three cycles, new id pc=0x104 -> ex_pc_o stays 0x100, id_ex_ready_o=0; ex_ready_i=1 -> 0x104 next cycle.
REQ-031 Load-use: ex holds load rd=5, id rs1=5 -> load_use_stall_o=1, id_ex_ready_o=0, next cycle bubble; following cycle instruction captured.
REQ-032 x0 load: ex load rd=0, id rs1=0 -> load_use_stall_o=0, accept same cycle.
REQ-033 Flush with hold and stall: flush_i=1, ex_ready_i=0, load-use active -> load_use_stall_o=0, id_ex_ready_o=1, next cycle ex_valid_o=0, ex_reg_we_o=0.
REQ-034 Async reset: rst_n low between edges while ex_valid_o=1 -> ex_valid_o=0, ex_ALUctrl_o=`NO_OP before next edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold, load-use bubble insertion and flush.
// Bubbles clear valid and write-enable, set ALUctrl to NO_OP, and zero every other field.
`ifndef Itype_L
`define Itype_L 7'b0000011
`endif
`ifndef NO_OP
`define NO_OP 5'b11111
`endif
`ifndef ADD
`define ADD 5'b00000
`endif

module id_ex_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid_i,
   input  logic [31:0] id_pc_i,
   input  logic [31:0] id_rs1_data_i,
   input  logic [31:0] id_rs2_data_i,
   input  logic [31:0] id_imm_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic [4:0]  id_rd_addr_i,
   input  logic [6:0]  id_opcode_i,
   input  logic [2:0]  id_func3_i,
   input  logic [4:0]  cu_ALUctrl_i,
   input  logic        cu_reg_we_i,
   input  logic        ex_ready_i,
   input  logic        flush_i,
   output logic        id_ex_ready_o,
   output logic        load_use_stall_o,
   output logic        ex_valid_o,
   output logic [31:0] ex_pc_o,
   output logic [31:0] ex_rs1_data_o,
   output logic [31:0] ex_rs2_data_o,
   output logic [31:0] ex_imm_o,
   output logic [4:0]  ex_rs1_addr_o,
   output logic [4:0]  ex_rs2_addr_o,
   output logic [4:0]  ex_rd_addr_o,
   output logic [6:0]  ex_opcode_o,
   output logic [2:0]  ex_func3_o,
   output logic [4:0]  ex_ALUctrl_o,
   output logic        ex_reg_we_o
);

   logic hold_s;
   logic free_s;
   logic rd_match_s;
   logic bubble_s;
   logic capture_s;

   // Hazard detection and accept/bubble decisions; flush overrides hold and stall.
   always_comb begin
      hold_s     = ex_valid_o & ~ex_ready_i;
      free_s     = ~hold_s;
      rd_match_s = (ex_rd_addr_o == id_rs1_addr_i) | (ex_rd_addr_o == id_rs2_addr_i);
      load_use_stall_o = ~flush_i & id_valid_i & ex_valid_o
                       & (ex_opcode_o == `Itype_L)
                       & (ex_rd_addr_o != 5'd0) & rd_match_s;
      id_ex_ready_o = flush_i | (free_s & ~load_use_stall_o);
      bubble_s  = flush_i | (free_s & (load_use_stall_o | ~id_valid_i));
      capture_s = ~flush_i & free_s & ~load_use_stall_o & id_valid_i;
   end

   // Stage register: reset/bubble, capture, or hold by leaving state untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_o    <= 1'b0;
         ex_pc_o       <= 32'd0;
         ex_rs1_data_o <= 32'd0;
         ex_rs2_data_o <= 32'd0;
         ex_imm_o      <= 32'd0;
         ex_rs1_addr_o <= 5'd0;
         ex_rs2_addr_o <= 5'd0;
         ex_rd_addr_o  <= 5'd0;
         ex_opcode_o   <= 7'd0;
         ex_func3_o    <= 3'd0;
         ex_ALUctrl_o  <= `NO_OP;
         ex_reg_we_o   <= 1'b0;
      end else if (bubble_s) begin
         ex_valid_o    <= 1'b0;
         ex_pc_o       <= 32'd0;
         ex_rs1_data_o <= 32'd0;
         ex_rs2_data_o <= 32'd0;
         ex_imm_o      <= 32'd0;
         ex_rs1_addr_o <= 5'd0;
         ex_rs2_addr_o <= 5'd0;
         ex_rd_addr_o  <= 5'd0;
         ex_opcode_o   <= 7'd0;
         ex_func3_o    <= 3'd0;
         ex_ALUctrl_o  <= `NO_OP;
         ex_reg_we_o   <= 1'b0;
      end else if (capture_s) begin
         ex_valid_o    <= 1'b1;
         ex_pc_o       <= id_pc_i;
         ex_rs1_data_o <= id_rs1_data_i;
         ex_rs2_data_o <= id_rs2_data_i;
         ex_imm_o      <= id_imm_i;
         ex_rs1_addr_o <= id_rs1_addr_i;
         ex_rs2_addr_o <= id_rs2_addr_i;
         ex_rd_addr_o  <= id_rd_addr_i;
         ex_opcode_o   <= id_opcode_i;
         ex_func3_o    <= id_func3_i;
         ex_ALUctrl_o  <= cu_ALUctrl_i;
         ex_reg_we_o   <= cu_reg_we_i;
      end else begin
         ex_valid_o    <= ex_valid_o;
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios plus randomized traffic
// compared against a rule-level reference model of the stage register.
`ifndef Itype_L
`define Itype_L 7'b0000011
`endif
`ifndef NO_OP
`define NO_OP 5'b11111
`endif
`ifndef ADD
`define ADD 5'b00000
`endif

module tb_id_ex_reg;
   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [159:0] BUBBLE = {154'd0, `NO_OP, 1'b0};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid_i = 1'b0;
   logic [31:0] id_pc_i = 32'd0, id_rs1_data_i = 32'd0, id_rs2_data_i = 32'd0, id_imm_i = 32'd0;
   logic [4:0]  id_rs1_addr_i = 5'd0, id_rs2_addr_i = 5'd0, id_rd_addr_i = 5'd0;
   logic [6:0]  id_opcode_i = 7'd0;
   logic [2:0]  id_func3_i = 3'd0;
   logic [4:0]  cu_ALUctrl_i = 5'd0;
   logic        cu_reg_we_i = 1'b0;
   logic        ex_ready_i = 1'b1;
   logic        flush_i = 1'b0;
   logic        id_ex_ready_o, load_use_stall_o, ex_valid_o, ex_reg_we_o;
   logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_ALUctrl_o;
   logic [6:0]  ex_opcode_o;
   logic [2:0]  ex_func3_o;

   int n_vec = 0;
   int n_err = 0;
   logic [159:0] m_ex = BUBBLE;

   id_ex_reg dut (
      .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
      .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
      .id_opcode_i(id_opcode_i), .id_func3_i(id_func3_i), .cu_ALUctrl_i(cu_ALUctrl_i),
      .cu_reg_we_i(cu_reg_we_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
      .id_ex_ready_o(id_ex_ready_o), .load_use_stall_o(load_use_stall_o),
      .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o),
      .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o), .ex_rs1_addr_o(ex_rs1_addr_o),
      .ex_rs2_addr_o(ex_rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o), .ex_opcode_o(ex_opcode_o),
      .ex_func3_o(ex_func3_o), .ex_ALUctrl_o(ex_ALUctrl_o), .ex_reg_we_o(ex_reg_we_o)
   );

   always #5 clk = ~clk;

   wire [159:0] dut_ex = {ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
                          ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_opcode_o,
                          ex_func3_o, ex_ALUctrl_o, ex_reg_we_o};
   wire [159:0] id_vec = {1'b1, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
                          id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_opcode_i,
                          id_func3_i, cu_ALUctrl_i, cu_reg_we_i};

   // Model view: valid [159], rd [20:16], opcode [15:9]
   function automatic logic exp_stall();
      logic [4:0] rd;
      rd = m_ex[20:16];
      return !flush_i && id_valid_i && m_ex[159] && (m_ex[15:9] == `Itype_L)
             && (rd != 5'd0) && (rd == id_rs1_addr_i || rd == id_rs2_addr_i);
   endfunction

   function automatic logic exp_ready();
      return flush_i || (!(m_ex[159] && !ex_ready_i) && !exp_stall());
   endfunction

   task automatic step();
      logic [159:0] nx;
      if (flush_i)                       nx = BUBBLE;
      else if (m_ex[159] && !ex_ready_i) nx = m_ex;
      else if (exp_stall())              nx = BUBBLE;
      else if (id_valid_i)               nx = id_vec;
      else                               nx = BUBBLE;
      @(posedge clk);
      #1;
      m_ex = nx;
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [6:0] op, input logic [4:0] alu,
                         input logic we);
      id_valid_i = 1'b1;
      id_pc_i = pc; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
      id_opcode_i = op; cu_ALUctrl_i = alu; cu_reg_we_i = we;
      id_rs1_data_i = $urandom; id_rs2_data_i = $urandom; id_imm_i = $urandom;
      id_func3_i = 3'($urandom_range(0, 7));
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if (dut_ex !== BUBBLE) begin n_err++; $display("FAIL reset_state got %h want %h", dut_ex, BUBBLE); end
      n_vec++;
      if (id_ex_ready_o !== 1'b1 || load_use_stall_o !== 1'b0) begin
         n_err++; $display("FAIL reset_comb got ready=%b stall=%b want 1 0", id_ex_ready_o, load_use_stall_o);
      end
      rst_n = 1'b1;
      m_ex = BUBBLE;
      @(negedge clk);
   endtask

   task automatic test_accept();
      ex_ready_i = 1'b1;
      set_id(32'h100, 5'd1, 5'd2, 5'd3, OP_R, `ADD, 1'b1);
      step();
      n_vec++;
      if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h100 || ex_ALUctrl_o !== `ADD || ex_reg_we_o !== 1'b1) begin
         n_err++; $display("FAIL accept got v=%b pc=%h alu=%h we=%b want 1 100 %h 1", ex_valid_o, ex_pc_o, ex_ALUctrl_o, ex_reg_we_o, `ADD);
      end
      n_vec++;
      if (dut_ex !== m_ex) begin n_err++; $display("FAIL accept_all got %h want %h", dut_ex, m_ex); end
   endtask

   task automatic test_hold();
      ex_ready_i = 1'b0;
      set_id(32'h104, 5'd6, 5'd7, 5'd8, OP_R, 5'd2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (id_ex_ready_o !== 1'b0) begin n_err++; $display("FAIL hold_ready cyc%0d got %b want 0", i, id_ex_ready_o); end
         step();
         n_vec++;
         if (ex_pc_o !== 32'h100 || dut_ex !== m_ex) begin
            n_err++; $display("FAIL hold_keep cyc%0d got pc=%h want 100", i, ex_pc_o);
         end
      end
      ex_ready_i = 1'b1;
      #1;
      n_vec++;
      if (id_ex_ready_o !== 1'b1) begin n_err++; $display("FAIL hold_release got %b want 1", id_ex_ready_o); end
      step();
      n_vec++;
      if (ex_pc_o !== 32'h104 || ex_valid_o !== 1'b1) begin n_err++; $display("FAIL hold_next got pc=%h v=%b want 104 1", ex_pc_o, ex_valid_o); end
   endtask

   task automatic test_load_use();
      set_id(32'h200, 5'd1, 5'd2, 5'd5, `Itype_L, `ADD, 1'b1);
      step();
      set_id(32'h204, 5'd5, 5'd9, 5'd10, OP_R, 5'd4, 1'b1);
      n_vec++;
      if (load_use_stall_o !== 1'b1 || id_ex_ready_o !== 1'b0) begin
         n_err++; $display("FAIL lu_detect got stall=%b ready=%b want 1 0", load_use_stall_o, id_ex_ready_o);
      end
      step();
      n_vec++;
      if (dut_ex !== BUBBLE) begin n_err++; $display("FAIL lu_bubble got %h want %h", dut_ex, BUBBLE); end
      n_vec++;
      if (load_use_stall_o !== 1'b0 || id_ex_ready_o !== 1'b1) begin
         n_err++; $display("FAIL lu_clear got stall=%b ready=%b want 0 1", load_use_stall_o, id_ex_ready_o);
      end
      step();
      n_vec++;
      if (ex_pc_o !== 32'h204 || dut_ex !== m_ex) begin n_err++; $display("FAIL lu_capture got pc=%h want 204", ex_pc_o); end
   endtask

   task automatic test_x0_load();
      set_id(32'h300, 5'd1, 5'd2, 5'd0, `Itype_L, `ADD, 1'b0);
      step();
      set_id(32'h304, 5'd0, 5'd0, 5'd11, OP_R, `ADD, 1'b1);
      n_vec++;
      if (load_use_stall_o !== 1'b0 || id_ex_ready_o !== 1'b1) begin
         n_err++; $display("FAIL x0_stall got stall=%b ready=%b want 0 1", load_use_stall_o, id_ex_ready_o);
      end
      step();
      n_vec++;
      if (ex_pc_o !== 32'h304 || ex_valid_o !== 1'b1) begin n_err++; $display("FAIL x0_accept got pc=%h want 304", ex_pc_o); end
   endtask

   task automatic test_flush();
      set_id(32'h400, 5'd1, 5'd2, 5'd5, `Itype_L, `ADD, 1'b1);
      step();
      set_id(32'h404, 5'd5, 5'd5, 5'd12, OP_R, `ADD, 1'b1);
      ex_ready_i = 1'b0;
      flush_i = 1'b1;
      #1;
      n_vec++;
      if (load_use_stall_o !== 1'b0 || id_ex_ready_o !== 1'b1) begin
         n_err++; $display("FAIL flush_comb got stall=%b ready=%b want 0 1", load_use_stall_o, id_ex_ready_o);
      end
      step();
      n_vec++;
      if (ex_valid_o !== 1'b0 || ex_reg_we_o !== 1'b0 || dut_ex !== BUBBLE) begin
         n_err++; $display("FAIL flush_bubble got v=%b we=%b want 0 0", ex_valid_o, ex_reg_we_o);
      end
      flush_i = 1'b0;
      ex_ready_i = 1'b1;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         set_id(32'h500 + 32'(4 * i), 5'd1, 5'd2, 5'(i + 3), OP_R, 5'(i), 1'b1);
         step();
         n_vec++;
         if (ex_pc_o !== 32'h500 + 32'(4 * i) || dut_ex !== m_ex) begin
            n_err++; $display("FAIL b2b_%0d got pc=%h want %h", i, ex_pc_o, 32'h500 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_async_reset();
      set_id(32'h600, 5'd1, 5'd2, 5'd3, OP_R, `ADD, 1'b1);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (ex_valid_o !== 1'b0 || ex_ALUctrl_o !== `NO_OP || dut_ex !== BUBBLE) begin
         n_err++; $display("FAIL async_reset got v=%b alu=%h want 0 %h", ex_valid_o, ex_ALUctrl_o, `NO_OP);
      end
      m_ex = BUBBLE;
      rst_n = 1'b1;
      id_valid_i = 1'b0;
      #1;
      step();
      n_vec++;
      if (dut_ex !== BUBBLE) begin n_err++; $display("FAIL post_reset_drain got %h want %h", dut_ex, BUBBLE); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_id($urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? `Itype_L : OP_R,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         id_valid_i = ($urandom_range(0, 3) != 0);
         ex_ready_i = ($urandom_range(0, 3) != 0);
         flush_i    = ($urandom_range(0, 9) == 0);
         #1;
         n_vec++;
         if (load_use_stall_o !== exp_stall() || id_ex_ready_o !== exp_ready()) begin
            n_err++; $display("FAIL rand_comb_%0d got stall=%b ready=%b want %b %b", i, load_use_stall_o, id_ex_ready_o, exp_stall(), exp_ready());
         end
         step();
         n_vec++;
         if (dut_ex !== m_ex) begin n_err++; $display("FAIL rand_state_%0d got %h want %h", i, dut_ex, m_ex); end
         n_vec++;
         if (ex_reg_we_o === 1'b1 && ex_valid_o !== 1'b1) begin
            n_err++; $display("FAIL rand_we_valid_%0d got we=1 v=%b want v=1", i, ex_valid_o);
         end
      end
      flush_i = 1'b0;
      ex_ready_i = 1'b1;
   endtask

   initial begin
      test_reset();
      test_accept();
      test_hold();
      test_load_use();
      test_x0_load();
      test_flush();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
